// File: rtl/im_loader_if.sv
// Byte-stream loader bus: program bytes in, instruction-memory write port
// and status out. The loader itself uses the slave side.
interface im_loader_if #(
    parameter int AW = 10
);
    logic          start;
    logic          end_load;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          we;
    logic [AW-1:0] waddr;
    logic [31:0]   wdata;
    logic          busy;
    logic          done;
    logic [AW:0]   word_count;

    modport master (
        output start, end_load, byte_valid, byte_data,
        input  byte_ready, we, waddr, wdata, busy, done, word_count
    );

    modport slave (
        input  start, end_load, byte_valid, byte_data,
        output byte_ready, we, waddr, wdata, busy, done, word_count
    );
endinterface

// File: rtl/im_loader.sv
// Instruction-memory loader: packs a big-endian byte stream into 32-bit
// words and writes them to consecutive word addresses starting at 0.
// A trailing partial word is zero-padded in the low bytes.
module im_loader #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic        clk,
    input  logic        reset,
    im_loader_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

    state_t        state;
    state_t        state_nx;
    logic [1:0]    idx;
    logic [1:0]    idx_nx;
    logic [31:0]   asm_word;
    logic [31:0]   asm_nx;
    logic [AW-1:0] next_addr;
    logic [AW:0]   count;
    logic          xfer;
    logic          word_full;
    logic          last_word;
    logic          ready;
    logic          we_p1;
    logic [AW-1:0] waddr_p1;
    logic [31:0]   wdata_p1;

    // Left-justify the n bytes held in the low end of a partial word.
    function automatic logic [31:0] pad_word(input logic [31:0] partial,
                                             input logic [1:0]  n);
        logic [31:0] r;
        case (n)
            2'd1:    r = {partial[7:0],  24'h0};
            2'd2:    r = {partial[15:0], 16'h0};
            2'd3:    r = {partial[23:0], 8'h0};
            default: r = partial;
        endcase
        return r;
    endfunction

    // Byte acceptance and next-value view of the assembly path.
    always_comb begin
        xfer      = bus.byte_valid && ready;
        idx_nx    = xfer ? idx + 2'd1 : idx;
        asm_nx    = xfer ? {asm_word[23:0], bus.byte_data} : asm_word;
        word_full = xfer && (idx == 2'd3);
        last_word = word_full && (next_addr == AW'(DEPTH - 1));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    // Next-state logic and state-decoded status outputs.
    always_comb begin
        state_nx = state;
        ready    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (bus.start) state_nx = LOAD;
            end
            LOAD: begin
                ready = 1'b1;
                // Memory full wins over end_load; a byte landing with
                // end_load is counted before the end is evaluated.
                if (last_word)         state_nx = DONE;
                else if (bus.end_load) state_nx = (idx_nx == 2'd0) ? DONE : FLUSH;
            end
            FLUSH: state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    // Word assembly, address/count tracking and the registered write port.
    always_ff @(posedge clk) begin
        if (!reset) begin
            idx       <= 2'd0;
            asm_word  <= 32'h0;
            next_addr <= '0;
            count     <= '0;
            we_p1     <= 1'b0;
            waddr_p1  <= '0;
            wdata_p1  <= 32'h0;
        end else begin
            we_p1 <= 1'b0;
            if ((state == IDLE || state == DONE) && bus.start) begin
                idx       <= 2'd0;
                asm_word  <= 32'h0;
                next_addr <= '0;
                count     <= '0;
            end else if (state == LOAD) begin
                idx      <= idx_nx;
                asm_word <= asm_nx;
                if (word_full) begin
                    we_p1     <= 1'b1;
                    waddr_p1  <= next_addr;
                    wdata_p1  <= asm_nx;
                    // The final slot leaves the pointer parked, no wrap.
                    next_addr <= last_word ? next_addr : next_addr + AW'(1);
                    count     <= count + 1'b1;
                end else if (bus.end_load && idx_nx != 2'd0) begin
                    we_p1     <= 1'b1;
                    waddr_p1  <= next_addr;
                    wdata_p1  <= pad_word(asm_nx, idx_nx);
                    next_addr <= next_addr + AW'(1);
                    count     <= count + 1'b1;
                end
            end
        end
    end

    assign bus.byte_ready = ready;
    assign bus.busy       = (state == LOAD) || (state == FLUSH);
    assign bus.done       = (state == DONE);
    assign bus.we         = we_p1;
    assign bus.waddr      = waddr_p1;
    assign bus.wdata      = wdata_p1;
    assign bus.word_count = count;

endmodule

// File: doc/im_loader.md
IM_LOADER -- requirements
Module: im_loader

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning instruction-memory words (word address = PC[11:2]).
REQ-002 SHALL have parameter AW, default 10, meaning write-address width (log2 DEPTH).
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on rising clk.
REQ-005 start  input  1  one-cycle request to begin a load at word address 0.
REQ-006 end_load  input  1  one-cycle marker: no more bytes in this load.
REQ-007 byte_valid  input  1  byte_data holds a valid byte.
REQ-008 byte_data  input  8  program byte; first byte of each word is bits [31:24].
REQ-009 byte_ready  output  1  loader accepts a byte this cycle; transfer = byte_valid && byte_ready.
REQ-010 we  output  1  one-cycle write strobe to instruction memory.
REQ-011 waddr  output  AW  word address for the write.
REQ-012 wdata  output  32  instruction word to write.
REQ-013 busy  output  1  high in LOAD or FLUSH.
REQ-014 done  output  1  high in DONE.
REQ-015 word_count  output  AW+1  words written in the current or last load.

Function
REQ-016 SHALL implement states IDLE, LOAD, FLUSH, DONE.
REQ-017 IDLE: start -> LOAD; clear byte index, assembly register, next address, word_count.
REQ-018 DONE: start -> LOAD with the same clears; otherwise stay in DONE.
REQ-019 start in LOAD or FLUSH SHALL be ignored.
REQ-020 byte_ready SHALL be 1 only in LOAD; 0 in IDLE, FLUSH, DONE.
REQ-021 Each transfer SHALL shift byte_data into the assembly register, big-endian, and advance byte index mod 4.
REQ-022 The cycle after the 4th byte of a word is accepted: we=1, waddr=next address, wdata=assembled word; next address and word_count increment by 1.
REQ-023 we, waddr, wdata SHALL be registered outputs; we is high for exactly one cycle per word.
REQ-024 end_load in LOAD with byte index 0 after any same-cycle transfer -> DONE.
REQ-025 end_load in LOAD with byte index 1-3 after any same-cycle transfer -> FLUSH; that cycle's FLUSH write zero-pads missing low bytes, then -> DONE.
REQ-026 end_load coincident with a transfer: byte SHALL be accepted first, then end_load applied.
REQ-027 After the DEPTH-th word write, SHALL go to DONE regardless of end_load; byte_ready drops in the cycle that write is issued; no address wrap.
REQ-028 end_load outside LOAD SHALL be ignored; byte_valid while byte_ready=0 SHALL be ignored (byte not consumed).
REQ-029 word_count SHALL hold its value in DONE until the next start.

Reset
REQ-030 reset=0 at a rising edge SHALL force IDLE, byte_ready=0, we=0, waddr=0, wdata=0, busy=0, done=0, word_count=0, byte index 0, assembly register 0.
REQ-031 reset during LOAD or FLUSH SHALL abort with no further write; a partial word is discarded.
REQ-032 reset SHALL take priority over start, end_load and byte transfers in the same cycle.

Verification
REQ-033 Reset: hold reset=0 two cycles -> all outputs 0, state IDLE.
REQ-034 Full words: start; bytes 12 34 56 78 9A BC DE F0; end_load -> writes (0, 0x12345678), (1, 0x9ABCDEF0); done=1, word_count=2.
REQ-035 Partial word: start; bytes AA BB CC DD 11 22; end_load -> writes (0, 0xAABBCCDD), then FLUSH write (1, 0x11220000); word_count=2.
REQ-036 Fill: start; 4096 bytes with byte_valid gaps -> 1024 writes, last at waddr 0x3FF; DONE, byte_ready=0, word_count=1024; extra bytes not consumed.
REQ-037 Abort: start; bytes 01 02; reset=0 -> no write, IDLE; start; bytes 0A 0B 0C 0D; end_load -> single write (0, 0x0A0B0C0D).
REQ-038 Coincident end: end_load in the same cycle as the 4th byte 44 of 11 22 33 44 -> write (0, 0x11223344), no FLUSH write, DONE.
